// File: rtl/operand_decode_pkg.sv
// rtl/operand_decode_pkg.sv - shared processor constants and instruction classifier
// Opcode fields, the register-31 select and the bubble word used by the decode stage.
package operand_decode_pkg;

  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [5:0]  OP_B     = 6'h05;
  localparam logic [31:0] SEL_ZERO = 32'h8000_0000;
  localparam logic [31:0] BUBBLE   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    K_ALU,
    K_LDUR,
    K_STUR,
    K_CBZ,
    K_B
  } instr_kind_e;

  // Anything not recognised is a register-writing ALU op, including the bubble.
  function automatic instr_kind_e classify(input logic [31:0] w);
    instr_kind_e k;
    if (w[31:21] == OP_LDUR)      k = K_LDUR;
    else if (w[31:21] == OP_STUR) k = K_STUR;
    else if (w[31:24] == OP_CBZ)  k = K_CBZ;
    else if (w[31:26] == OP_B)    k = K_B;
    else                          k = K_ALU;
    return k;
  endfunction

endpackage

// File: rtl/operand_decode_if.sv
// rtl/operand_decode_if.sv - fetch/decode bus between fetch, decode and register file
// Master is the fetch side driving ibus; slave is the decode stage.
interface operand_decode_if;

  logic [31:0] ibus;
  logic        ivalid;
  logic        flush;
  logic        stall;
  logic [31:0] Aselect;
  logic [31:0] Bselect;
  logic [31:0] Dselect;

  modport master (
    output ibus, ivalid, flush,
    input  stall, Aselect, Bselect, Dselect
  );

  modport slave (
    input  ibus, ivalid, flush,
    output stall, Aselect, Bselect, Dselect
  );

endinterface

// File: rtl/operand_decode_dec5to32.sv
// rtl/operand_decode_dec5to32.sv - 5-bit register index to 32-bit one-hot select
module dec5to32 (
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);

  assign onehot = 32'h1 << idx;

endmodule

// File: rtl/operand_decode.sv
// rtl/operand_decode.sv - ID-stage operand decode with load-use stall and destination pipe
// Holds the ID instruction and carries one-hot destinations through EX, MEM and WB.
module operand_decode
  import operand_decode_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  operand_decode_if.slave  bus
);

  logic [31:0] id_q, id_d;
  logic [31:0] ex_dst_q, ex_dst_d;
  logic [31:0] mem_dst_q, mem_dst_d;
  logic [31:0] wb_dst_q, wb_dst_d;
  logic        ex_load_q, ex_load_d;

  instr_kind_e kind;
  logic [4:0]  b_idx;
  logic [31:0] rn_sel, b_sel, rd_sel;
  logic [31:0] a_out, b_out, id_dst;
  logic        hazard;

  assign kind  = classify(id_q);
  // Stores and CBZ read their data register through the Rt field on port B.
  assign b_idx = (kind == K_STUR || kind == K_CBZ) ? id_q[4:0] : id_q[20:16];

  dec5to32 u_dec_rn (.idx(id_q[9:5]), .onehot(rn_sel));
  dec5to32 u_dec_rb (.idx(b_idx),     .onehot(b_sel));
  dec5to32 u_dec_rd (.idx(id_q[4:0]), .onehot(rd_sel));

  always_comb begin
    a_out  = rn_sel;
    b_out  = b_sel;
    id_dst = rd_sel;
    unique case (kind)
      K_LDUR: b_out = SEL_ZERO;
      K_STUR: id_dst = SEL_ZERO;
      K_CBZ:  id_dst = SEL_ZERO;
      K_B: begin
        a_out  = SEL_ZERO;
        b_out  = SEL_ZERO;
        id_dst = SEL_ZERO;
      end
      default: ;
    endcase
  end

  // Register 31 reads as zero, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = ex_load_q && (ex_dst_q != SEL_ZERO) &&
             (((ex_dst_q & a_out) != '0) || ((ex_dst_q & b_out) != '0));
  end

  assign bus.stall   = hazard && !bus.flush;
  assign bus.Aselect = a_out;
  assign bus.Bselect = b_out;
  assign bus.Dselect = wb_dst_q;

  always_comb begin
    id_d      = id_q;
    ex_dst_d  = ex_dst_q;
    ex_load_d = ex_load_q;
    mem_dst_d = ex_dst_q;
    wb_dst_d  = mem_dst_q;
    if (bus.flush) begin
      id_d      = BUBBLE;
      ex_dst_d  = SEL_ZERO;
      ex_load_d = 1'b0;
    end else if (hazard) begin
      ex_dst_d  = SEL_ZERO;
      ex_load_d = 1'b0;
    end else begin
      id_d      = bus.ivalid ? bus.ibus : BUBBLE;
      ex_dst_d  = id_dst;
      ex_load_d = (kind == K_LDUR);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      id_q      <= BUBBLE;
      ex_dst_q  <= SEL_ZERO;
      ex_load_q <= 1'b0;
      mem_dst_q <= SEL_ZERO;
      wb_dst_q  <= SEL_ZERO;
    end else begin
      id_q      <= id_d;
      ex_dst_q  <= ex_dst_d;
      ex_load_q <= ex_load_d;
      mem_dst_q <= mem_dst_d;
      wb_dst_q  <= wb_dst_d;
    end
  end

endmodule

// File: doc/operand_decode.md
OPERAND_DECODE -- requirements
Module: operand_decode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: nreset  input  1  reset; synchronous and active-low.
REQ-003 SHALL have port: ibus  input  32  fetched A64 instruction word.
REQ-004 SHALL have port: ivalid  input  1  ibus holds a valid instruction this cycle.
REQ-005 SHALL have port: flush  input  1  discard the instruction in the ID register (taken branch).
REQ-006 SHALL have port: stall  output  1  fetch must hold ibus; ID register is not loading.
REQ-007 SHALL have port: Aselect  output  32  one-hot register-file A read select.
REQ-008 SHALL have port: Bselect  output  32  one-hot register-file B read select.
REQ-009 SHALL have port: Dselect  output  32  one-hot register-file write select, aligned with the writeback dbus.

Function
REQ-010 SHALL hold four stages of state: the ID instruction register plus EX, MEM and WB destination registers (32-bit one-hot each); EX also holds an is_load flag.
REQ-011 SHALL decode fields Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
REQ-012 SHALL classify the instruction: LDUR ([31:21]=11'h7C2), STUR ([31:21]=11'h7C0), CBZ ([31:24]=8'hB4), B ([31:26]=6'h05); every other encoding is treated as register-writing ALU.
REQ-013 SHALL drive Aselect combinationally from the ID register as one-hot(Rn); for B, Aselect = bit 31.
REQ-014 SHALL drive Bselect combinationally as one-hot(Rm) for ALU, one-hot(Rt) for STUR and CBZ, and bit 31 for LDUR and B.
REQ-015 SHALL compute the ID destination as one-hot(Rd) for ALU and LDUR, and bit 31 (SEL_ZERO, the discard target) for STUR, CBZ and B.
REQ-016 SHALL advance the destination ID->EX->MEM->WB one stage per cycle, with Dselect = WB register, so Dselect is asserted exactly 3 cycles after the instruction leaves ID.
REQ-017 SHALL load the ID register from ibus on a rising edge when ivalid=1, stall=0 and flush=0, and load a bubble when ivalid=0 and stall=0.
REQ-018 SHALL define a bubble as an instruction word with Rd=Rn=Rm=31 and no write (ID destination = SEL_ZERO); the value 32'hFFFF_FFFF is used.
REQ-019 SHALL assert stall combinationally when the EX stage holds a load, its destination is not SEL_ZERO, and that destination matches Aselect or Bselect of the ID instruction (load-use hazard).
REQ-020 SHALL, while stall=1, hold the ID register and load SEL_ZERO (bubble) into EX; MEM and WB advance normally.
REQ-021 SHALL give flush priority over stall and ivalid: when flush=1, ID loads a bubble, and EX receives the bubble that would otherwise have come from ID; stall is ignored in that cycle.
REQ-022 SHALL cause no stall for a dependency on register 31, which reads as zero.
REQ-023 SHALL cause no stall for a stalled instruction in its second cycle, because the load has moved to MEM by then.

Reset
REQ-024 SHALL, when nreset=0 at a rising edge, load a bubble into ID, SEL_ZERO into EX/MEM/WB and clear the EX is_load flag.
REQ-025 SHALL, in the cycle after reset, drive Aselect = Bselect = Dselect = 32'h8000_0000 and stall = 0.
REQ-026 SHALL give reset priority over flush, stall and ivalid, including reset asserted mid-stall.

Structure
REQ-027 SHALL place the opcode constants (LDUR, STUR, CBZ, B), SEL_ZERO (32'h8000_0000) and the bubble word in the shared processor package.
REQ-028 SHALL use one sub-module, dec5to32 (5-bit index to 32-bit one-hot), instantiated for Rn, Rm/Rt and Rd.

Verification
REQ-029 SHALL cover: after reset, ivalid=0 -> Aselect=Bselect=Dselect=32'h8000_0000 and stall=0 for 5 cycles.
REQ-030 SHALL cover: ADD X3,X1,X2 (32'h8B020023) -> Aselect=32'h2 and Bselect=32'h4 in ID, then Dselect=32'h8 exactly 3 cycles later for one cycle.
REQ-031 SHALL cover: LDUR X5,[X1] (32'hF8400025) followed by ADD X6,X5,X2 (32'h8B0200A6) -> stall=1 for exactly 1 cycle, then Dselect=32'h20 followed two cycles later by Dselect=32'h40.
REQ-032 SHALL cover: STUR X7,[X2] (32'hF8000047) -> Aselect=32'h4, Bselect=32'h80, and Dselect stays 32'h8000_0000.
REQ-033 SHALL cover: LDUR X31 followed by ADD X6,X31,X2 -> no stall.
REQ-034 SHALL cover: flush asserted during a stall cycle -> stall=0, and the dependent ADD never produces Dselect=32'h40.
